// File: rtl/siso_pkg.sv
// Shared types and width helpers for the serial shift-out sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package siso_pkg;

  // Controller states. The ST_ prefix keeps the GAP state name from colliding
  // with the GAP parameter of the controller.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Counter width for a counter that must hold the values 0..n-1.
  // Returns at least 1 so that degenerate counts still give a legal vector.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/siso_shift_ctrl_piso_shreg.sv
// N-bit parallel-in serial-out register: load, shift-left or hold; MSB is the serial bit.
// Latency: loaded word's MSB is visible the cycle after load; one bit per shift.
// Backpressure: none; the caller holds by deasserting both load and shift.
// Ports: clk, clear (sync, active-high), load, shift, din[N-1:0], msb.
module piso_shreg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         msb
);

  logic [N-1:0] shreg;

  // load wins over shift so a back-to-back reload on the last bit replaces
  // the exhausted word instead of shifting it.
  always_ff @(posedge clk) begin
    if (clear) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[N-2:0], 1'b0};
    end
  end

  assign msb = shreg[N-1];

endmodule

// File: rtl/siso_shift_ctrl.sv
// Sequencer serialising N-bit words MSB-first with a programmable idle gap after each word.
// Latency: first bit the cycle after handshake; N unstalled cycles per word; period N+GAP+1 (N if GAP=0).
// Backpressure: in_ready low while a word is in flight or during the gap; stall freezes shifting.
// Ports: clk, clear (sync, active-high), in_valid/in_data/in_ready (word input handshake),
//        stall, so/so_valid (serial output), busy (not idle), done (pulse after last bit).
module siso_shift_ctrl
  import siso_pkg::*;
#(
  parameter int N   = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         stall,
  output logic         so,
  output logic         so_valid,
  output logic         busy,
  output logic         done
);

  localparam int BW = cnt_w(N);
  localparam int GW = cnt_w(GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_t        state, state_nxt;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          done_q;

  logic          load;
  logic          shift;
  logic          last_bit;
  logic          rdy_c;
  logic          sov_c;
  logic          shreg_msb;

  piso_shreg #(.N(N)) u_shreg (
    .clk   (clk),
    .clear (clear),
    .load  (load),
    .shift (shift),
    .din   (in_data),
    .msb   (shreg_msb)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    last_bit  = 1'b0;
    rdy_c     = 1'b0;
    sov_c     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        rdy_c = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sov_c = ~stall;
        if (!stall) begin
          shift = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            last_bit = 1'b1;
            if (GAP == 0) begin
              // Back-to-back: accept the next word on the last bit, no dead cycle.
              rdy_c = 1'b1;
              if (in_valid) begin
                load      = 1'b1;
                state_nxt = ST_SHIFT;
              end else begin
                state_nxt = ST_IDLE;
              end
            end else begin
              state_nxt = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // The clear cycle accepts nothing.
    if (clear) begin
      load  = 1'b0;
      rdy_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= last_bit;
      // Return to 0 at the terminal count rather than wrapping past it.
      if (load || last_bit) begin
        bit_cnt <= '0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == ST_GAP && gap_cnt != GAP_LAST) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // Outputs are forced low during the clear cycle itself.
  assign in_ready = rdy_c;
  assign so_valid = sov_c & ~clear;
  assign so       = (state == ST_SHIFT) & shreg_msb & ~clear;
  assign busy     = (state != ST_IDLE) & ~clear;
  assign done     = done_q & ~clear;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
module tb_siso_shift_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  // instance 0: N=4 GAP=1, instance 1: N=4 GAP=0, instance 2: N=4 GAP=3
  logic       iv0, iv1, iv2;
  logic [3:0] d0, d1, d2;
  logic       st0, st1, st2;
  logic       ir0, ir1, ir2;
  logic       so0, so1, so2;
  logic       sv0, sv1, sv2;
  logic       bz0, bz1, bz2;
  logic       dn0, dn1, dn2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  siso_shift_ctrl #(.N(4), .GAP(1)) u0 (
    .clk(clk), .clear(clear), .in_valid(iv0), .in_data(d0), .in_ready(ir0),
    .stall(st0), .so(so0), .so_valid(sv0), .busy(bz0), .done(dn0));
  siso_shift_ctrl #(.N(4), .GAP(0)) u1 (
    .clk(clk), .clear(clear), .in_valid(iv1), .in_data(d1), .in_ready(ir1),
    .stall(st1), .so(so1), .so_valid(sv1), .busy(bz1), .done(dn1));
  siso_shift_ctrl #(.N(4), .GAP(3)) u2 (
    .clk(clk), .clear(clear), .in_valid(iv2), .in_data(d2), .in_ready(ir2),
    .stall(st2), .so(so2), .so_valid(sv2), .busy(bz2), .done(dn2));

  typedef struct {
    logic       clr;
    logic       iv;
    logic [3:0] d;
    logic       st;
    logic       so;
    logic       sv;
    logic       ir;
    logic       bz;
    logic       dn;
  } vec_t;

  vec_t vq[$];
  logic q1[$];
  logic q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic clr, input logic iv, input logic [3:0] d, input logic st,
                     input logic so, input logic sv, input logic ir, input logic bz,
                     input logic dn);
    vec_t v;
    v.clr = clr; v.iv = iv; v.d = d; v.st = st;
    v.so = so; v.sv = sv; v.ir = ir; v.bz = bz; v.dn = dn;
    vq.push_back(v);
  endtask

  task automatic push_word(input int which, input logic [3:0] w);
    logic [3:0] t;
    t = w;
    for (int b = 3; b >= 0; b--) begin
      if (which == 1) q1.push_back(t[b]);
      else            q2.push_back(t[b]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    iv0 = 0; iv1 = 0; iv2 = 0;
    d0 = 0; d1 = 0; d2 = 0;
    st0 = 0; st1 = 0; st2 = 0;

    // Scoreboard monitors for the serial streams of instances 1 and 2.
    fork
      forever begin
        logic e;
        @(negedge clk);
        if (sv1 === 1'b1) begin
          if (q1.size() == 0) chk("sb1_extra_bit", 1, 0);
          else begin e = q1.pop_front(); chk("sb1_so", so1, e); end
        end
        if (sv2 === 1'b1) begin
          if (q2.size() == 0) chk("sb2_extra_bit", 1, 0);
          else begin e = q2.pop_front(); chk("sb2_so", so2, e); end
        end
      end
    join_none

    // Vector table for instance 0 (GAP=1): clr iv d st | so sv ir bz dn
    add(1,0,4'h0,0, 0,0,0,0,0);   // clear cycle
    add(0,1,4'hB,0, 0,0,1,0,0);   // 1011 handshake
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h0,0, 0,1,0,1,0);
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h0,0, 0,0,0,1,1);   // gap, done
    add(0,1,4'h6,0, 0,0,1,0,0);   // 0110 handshake
    add(0,0,4'hF,0, 0,1,0,1,0);   // in_data toggles mid-word
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h9,0, 1,1,0,1,0);
    add(0,0,4'hF,0, 0,1,0,1,0);
    add(0,0,4'h0,0, 0,0,0,1,1);
    add(0,1,4'hC,0, 0,0,1,0,0);   // 1100 handshake
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h0,1, 1,0,0,1,0);   // stall 3 cycles on 2nd bit
    add(0,0,4'h0,1, 1,0,0,1,0);
    add(0,0,4'h0,1, 1,0,0,1,0);
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h0,0, 0,1,0,1,0);
    add(0,0,4'h0,0, 0,1,0,1,0);
    add(0,1,4'h3,1, 0,0,0,1,1);   // gap: stall ignored, no accept
    add(0,1,4'hF,0, 0,0,1,0,0);   // 1111 handshake
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(1,0,4'h0,0, 0,0,0,0,0);   // clear on 3rd bit
    add(0,0,4'h0,0, 0,0,1,0,0);   // idle, no done
    add(0,1,4'h5,1, 0,0,1,0,0);   // stall ignored in idle, 0101 handshake
    add(0,0,4'h0,0, 0,1,0,1,0);
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h0,0, 0,1,0,1,0);
    add(0,0,4'h0,0, 1,1,0,1,0);
    add(0,0,4'h0,0, 0,0,0,1,1);
    add(0,0,4'h0,0, 0,0,1,0,0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      tick();
      clear = vq[i].clr; iv0 = vq[i].iv; d0 = vq[i].d; st0 = vq[i].st;
      @(negedge clk);
      chk($sformatf("t%0d_so", i),       so0, vq[i].so);
      chk($sformatf("t%0d_so_valid", i), sv0, vq[i].sv);
      chk($sformatf("t%0d_in_ready", i), ir0, vq[i].ir);
      chk($sformatf("t%0d_busy", i),     bz0, vq[i].bz);
      chk($sformatf("t%0d_done", i),     dn0, vq[i].dn);
    end
    tick();
    clear = 1'b0; iv0 = 1'b0;

    // Back-to-back on GAP=0: A then 5, contiguous.
    begin
      int cnt;
      cnt = 0;
      iv1 = 1'b1; d1 = 4'hA;
      push_word(1, 4'hA);
      push_word(1, 4'h5);
      @(negedge clk);
      chk("b2b_rdy_idle", ir1, 1);
      tick();
      d1 = 4'h5;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (sv1 === 1'b1) cnt++;
        if (i == 0) chk("b2b_done_early", dn1, 0);
        if (i == 2) chk("b2b_rdy_mid", ir1, 0);
        if (i == 3) chk("b2b_rdy_last", ir1, 1);
        if (i == 4) chk("b2b_done_w1", dn1, 1);
        if (i == 4) chk("b2b_busy", bz1, 1);
        tick();
        if (i == 3) iv1 = 1'b0;
      end
      @(negedge clk);
      chk("b2b_done_w2", dn1, 1);
      chk("b2b_sv_after", sv1, 0);
      chk("b2b_idle", bz1, 0);
      chk("b2b_valid_cnt", cnt, 8);
      tick();
      @(negedge clk);
      chk("b2b_done_once", dn1, 0);
    end

    // in_valid held through shift and a 3-cycle gap on GAP=3.
    tick();
    iv2 = 1'b1; d2 = 4'h9;
    push_word(2, 4'h9);
    push_word(2, 4'h6);
    @(negedge clk);
    chk("gap_rdy_idle", ir2, 1);
    tick();
    d2 = 4'h6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("gap_rdy_shift%0d", i), ir2, 0);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("gap_rdy_gap%0d", j), ir2, 0);
      chk($sformatf("gap_sv_gap%0d", j), sv2, 0);
      chk($sformatf("gap_busy_gap%0d", j), bz2, 1);
      tick();
    end
    @(negedge clk);
    chk("gap_rdy_after", ir2, 1);
    chk("gap_busy_after", bz2, 0);
    tick();
    iv2 = 1'b0;
    for (int k = 0; k < 20 && q2.size() != 0; k++) tick();
    chk("sb2_drain", q2.size(), 0);
    chk("sb1_drain", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
